// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rise-to-rise period of an asynchronous
// PWM input and exposes them through an Avalon-MM register file with a level IRQ.
module pwm_capture #(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwm_in,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        irq
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMP_W  = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_WIDTH  = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             sync1_q, sync2_q, sync3_q;
  logic             rise_c, fall_c;
  logic             en_q, irq_en_q;
  logic [CNT_W-1:0] hi_cnt_q, per_cnt_q, hi_hold_q;
  logic [CNT_W-1:0] width_q, period_q;
  logic             valid_q, ovf_q, tmo_q;
  logic             start_c, latch_c, publish_c, timeout_c;
  logic             per_at_to_c, pub_sat_c;
  logic             wr_ctrl_c, wr_stat_c;
  logic [2:0]       clr_c;
  logic [31:0]      rdata_c;
  logic             unused_wdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Two-flop synchronizer plus edge-detect flop; both edges see equal delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_c      = sync2_q & ~sync3_q;
  assign fall_c      = ~sync2_q & sync3_q;
  assign per_at_to_c = (CMP_W'(per_cnt_q) == CMP_W'(TIMEOUT_CYCLES));
  assign pub_sat_c   = (hi_hold_q == CNT_MAX) | (per_cnt_q == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and measurement strobes; timeout outranks edges.
  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    latch_c   = 1'b0;
    publish_c = 1'b0;
    timeout_c = 1'b0;
    if (!en_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            start_c = 1'b1;
            state_d = ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (per_at_to_c) begin
            timeout_c = 1'b1;
            state_d   = ST_IDLE;
          end else if (fall_c) begin
            latch_c = 1'b1;
            state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (per_at_to_c) begin
            timeout_c = 1'b1;
            state_d   = ST_IDLE;
          end else if (rise_c) begin
            publish_c = 1'b1;
            state_d   = ST_HIGH;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_cnt_q  <= '0;
      per_cnt_q <= '0;
      hi_hold_q <= '0;
      width_q   <= '0;
      period_q  <= '0;
    end else begin
      if (start_c || publish_c) begin
        hi_cnt_q  <= CNT_W'(1);
        per_cnt_q <= CNT_W'(1);
      end else if (state_q == ST_HIGH) begin
        hi_cnt_q  <= sat_inc(hi_cnt_q);
        per_cnt_q <= sat_inc(per_cnt_q);
      end else if (state_q == ST_LOW) begin
        per_cnt_q <= sat_inc(per_cnt_q);
      end
      if (latch_c) hi_hold_q <= hi_cnt_q;
      if (publish_c) begin
        width_q  <= hi_hold_q;
        period_q <= per_cnt_q;
      end else if (timeout_c) begin
        width_q  <= '0;
        period_q <= '0;
      end
    end
  end

  assign wr_ctrl_c    = avs_write & (avs_address == ADDR_CTRL);
  assign wr_stat_c    = avs_write & (avs_address == ADDR_STATUS);
  assign clr_c        = wr_stat_c ? avs_writedata[2:0] : 3'b000;
  assign unused_wdata = ^avs_writedata[31:3];

  // Control and W1C status; a hardware set wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      if (wr_ctrl_c) begin
        en_q     <= avs_writedata[0];
        irq_en_q <= avs_writedata[1];
      end
      valid_q <= publish_c | (valid_q & ~clr_c[0] & ~timeout_c);
      ovf_q   <= (publish_c & pub_sat_c) | (ovf_q & ~clr_c[1]);
      tmo_q   <= timeout_c | (tmo_q & ~clr_c[2]);
    end
  end

  always_comb begin
    rdata_c = '0;
    case (avs_address)
      ADDR_CTRL:   rdata_c = {30'b0, irq_en_q, en_q};
      ADDR_WIDTH:  rdata_c = DATA_W'(width_q);
      ADDR_PERIOD: rdata_c = DATA_W'(period_q);
      ADDR_STATUS: rdata_c = {29'b0, tmo_q, ovf_q, valid_q};
      default:     rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      avs_readdata <= avs_read ? rdata_c : '0;
      irq          <= irq_en_q & (valid_q | tmo_q);
    end
  end

endmodule
